// File: rtl/bias_add_lanes_if.sv
// Beat stream between the systolic array column outputs and the bias-add stage.
// The master drives beats in and takes results out; the slave is the bias-add stage.
interface bias_add_lanes_if #(
    parameter int LANES = 4,
    parameter int W     = 32,
    parameter int SW    = 2
) ();
    logic                 in_valid;
    logic                 in_ready;
    logic [LANES*W-1:0]   in_data;
    logic [SW-1:0]        in_set;
    logic [1:0]           in_mode;
    logic                 out_valid;
    logic                 out_ready;
    logic [LANES*W-1:0]   out_data;

    modport master (
        output in_valid, in_data, in_set, in_mode, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, in_set, in_mode, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/bias_add_lanes.sv
// Multi-lane bias add (D = A*B + C) with banked per-lane biases, wrap/saturate/ReLU
// modes, a two-stage valid/ready pipeline and a saturation-event counter.
module bias_add_lanes #(
    parameter int LANES = 4,
    parameter int W     = 32,
    parameter int SETS  = 4,
    parameter int SW    = 2,
    parameter int CW    = 16,
    localparam int LW   = (LANES > 1) ? $clog2(LANES) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                bias_wr_en,
    input  logic [SW-1:0]       bias_wr_set,
    input  logic [LW-1:0]       bias_wr_lane,
    input  logic signed [W-1:0] bias_wr_data,
    input  logic                sat_clr,
    output logic [CW-1:0]       sat_cnt,
    bias_add_lanes_if.slave     bus
);
    typedef logic signed [W-1:0] word_t;
    typedef logic signed [W:0]   wide_t;

    localparam word_t MAX_V = {1'b0, {(W-1){1'b1}}};
    localparam word_t MIN_V = {1'b1, {(W-1){1'b0}}};

    // A lane clamps when the W+1-bit sum does not fit in W bits; wrap mode never counts.
    function automatic logic lane_clamped(input wide_t s, input logic [1:0] mode);
        return (mode != 2'd0) && (s[W] != s[W-1]);
    endfunction

    function automatic word_t lane_result(input wide_t s, input logic [1:0] mode);
        word_t r;
        r = s[W-1:0];
        if (mode != 2'd0) begin
            if (s[W] != s[W-1])
                r = s[W] ? MIN_V : MAX_V;
            if (mode == 2'd2 && r[W-1])
                r = '0;
        end
        return r;
    endfunction

    word_t              bank_q [SETS][LANES];
    wide_t              sum_p1_q [LANES];
    wide_t              sum_d [LANES];
    logic [1:0]         mode_p1_q;
    logic               vld_p1_q;
    logic [LANES*W-1:0] out_p2_q;
    logic [LANES*W-1:0] out_d;
    logic               vld_p2_q;
    logic               clamp_d;
    logic [CW-1:0]      sat_cnt_q;
    logic [CW-1:0]      sat_cnt_d;
    logic               s1_en;
    logic               s2_en;
    logic               accept;

    assign s2_en  = !vld_p2_q || bus.out_ready;
    assign s1_en  = !vld_p1_q || s2_en;
    assign accept = bus.in_valid && s1_en;

    assign bus.in_ready  = s1_en;
    assign bus.out_valid = vld_p2_q;
    assign bus.out_data  = out_p2_q;
    assign sat_cnt       = sat_cnt_q;

    // Bank read happens before the write edge, so a colliding beat sees the old bias.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int s = 0; s < SETS; s++)
                for (int l = 0; l < LANES; l++)
                    bank_q[s][l] <= '0;
        end else if (bias_wr_en) begin
            bank_q[bias_wr_set][bias_wr_lane] <= bias_wr_data;
        end
    end

    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            sum_d[i] = {bus.in_data[i*W + W - 1], bus.in_data[i*W +: W]}
                     + {bank_q[bus.in_set][i][W-1], bank_q[bus.in_set][i]};
        end
    end

    // Stage 1: widened per-lane sums registered with the beat's mode.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p1_q  <= 1'b0;
            mode_p1_q <= 2'd0;
            for (int i = 0; i < LANES; i++)
                sum_p1_q[i] <= '0;
        end else if (s1_en) begin
            vld_p1_q  <= accept;
            mode_p1_q <= bus.in_mode;
            for (int i = 0; i < LANES; i++)
                sum_p1_q[i] <= sum_d[i];
        end
    end

    always_comb begin
        out_d   = '0;
        clamp_d = 1'b0;
        for (int i = 0; i < LANES; i++) begin
            out_d[i*W +: W] = lane_result(sum_p1_q[i], mode_p1_q);
            clamp_d         = clamp_d | lane_clamped(sum_p1_q[i], mode_p1_q);
        end
    end

    // Stage 2: mode-dependent wrap/clamp/ReLU; bubbles present zero data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p2_q <= 1'b0;
            out_p2_q <= '0;
        end else if (s2_en) begin
            vld_p2_q <= vld_p1_q;
            out_p2_q <= vld_p1_q ? out_d : '0;
        end
    end

    always_comb begin
        sat_cnt_d = sat_cnt_q;
        if (sat_clr)
            sat_cnt_d = '0;
        else if (s2_en && vld_p1_q && clamp_d && (sat_cnt_q != {CW{1'b1}}))
            sat_cnt_d = sat_cnt_q + CW'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            sat_cnt_q <= '0;
        else
            sat_cnt_q <= sat_cnt_d;
    end
endmodule

// File: doc/bias_add_lanes.md
Name: bias_add_lanes

Overview:
- Multi-lane, parametrised bias-add stage placed between the systolic array column outputs and the result writeback: computes D = A*B + C for LANES columns per beat.
- Holds SETS banks of per-lane bias values so per-layer bias switching needs no reload.
- Adds wrap, saturate and saturate+ReLU modes, a 2-stage valid/ready pipeline with backpressure, and a saturation-event counter.

Parameters:
- LANES, 4, number of parallel columns per beat.
- W, 32, signed width of data-in, bias and data-out.
- SETS, 4, number of bias banks; must be a power of two, at least 2.
- SW, 2, bank-select width, equal to log2(SETS).
- CW, 16, width of the saturation-event counter.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- bias_wr_en  in  1  write one bias word this cycle.
- bias_wr_set  in  SW  target bank.
- bias_wr_lane  in  log2(LANES) (min 1)  target lane.
- bias_wr_data  in  W  signed bias value.
- in_valid  in  1  input beat valid.
- in_ready  out  1  stage 1 can accept a beat.
- in_data  in  LANES*W  signed lane sums; lane i is at bits [i*W +: W].
- in_set  in  SW  bias bank used for this beat.
- in_mode  in  2  0=wrap, 1=saturate, 2=saturate+ReLU, 3=reserved (treated as 1).
- out_valid  out  1  output beat valid.
- out_ready  in  1  downstream accepts the beat.
- out_data  out  LANES*W  signed results, same lane packing as in_data.
- sat_clr  in  1  synchronous clear of sat_cnt.
- sat_cnt  out  CW  number of beats with at least one clamped lane; saturates at all-ones.

Behaviour:
- Reset (async): all bias banks=0, s1/s2 valid=0, out_valid=0, out_data=0, sat_cnt=0, in_ready=1 after reset deasserts. Reset mid-beat discards all in-flight beats; no partial output.
- Bias write: on a clk edge with bias_wr_en=1, bank[bias_wr_set][bias_wr_lane] <= bias_wr_data.
  - A beat accepted on the same edge that targets the same bank/lane uses the old value (bank read is pre-edge).
  - A write on the next cycle does not affect a beat already in stage 1.
- Handshake:
  - Transfer in occurs when in_valid and in_ready are both 1.
  - Transfer out occurs when out_valid and out_ready are both 1.
  - s2_en = !s2_valid || out_ready.
  - s1_en = !s1_valid || s2_en.
  - in_ready = s1_en (combinational from out_ready and valid flags).
  - Full throughput: 1 beat/cycle with out_ready held high.
  - Latency: 2 cycles from accept to out_valid.
  - Beats are never dropped or duplicated; order is preserved.
- Stage 1 (on s1_en): per lane, sum_i = sext(in_data_i) + sext(bank[in_set][i]) at W+1 bits. s1_valid <= accept. in_mode is registered with the beat.
- Stage 2 (on s2_en): s2_valid <= s1_valid.
  - Per lane, mode 0: result = sum[W-1:0] (two's-complement wrap).
  - Modes 1/3: clamp sum to [-2^(W-1), 2^(W-1)-1].
  - Mode 2: clamp, then negative results become 0.
  - If s1_valid=0, out_data <= 0. While stalled (s2_en=0), out_data and out_valid hold unchanged.
  - clamped flag: any lane clamped on a valid beat. Mode 0 never sets it. ReLU zeroing alone does not set it.
- sat_cnt:
  - Increments by 1 on each stage-2 load of a valid beat whose clamped flag is set.
  - Holds at 2^CW-1.
  - If sat_clr and an increment occur on the same edge, the clear wins and sat_cnt becomes 0.

Test Plan:
- Basic add (W=32, LANES=4): write bank1 biases {10,-20,30,-40}; send in_data {1,2,3,4}, in_set=1, mode 0, out_ready=1 -> 2 cycles later out_data {11,-18,33,-36}, out_valid 1 for exactly one cycle.
- Overflow modes, lane0=0x7FFFFFF0, bias 0x20:
  - mode 0 -> 0x80000010.
  - mode 1 -> 0x7FFFFFFF and sat_cnt 0->1.
  - lane0=-100, bias 50, mode 2 -> 0, sat_cnt unchanged.
- Backpressure: stream 6 beats with values 1..6; hold out_ready=0 for cycles 3-6 -> in_ready falls once both stages are full; outputs 1..6 emerge in order with no loss, and out_data holds stable while stalled.
- Bank switching and write collision:
  - Alternate in_set 0/2 per beat with distinct banks -> each output uses its own bank.
  - Bias write to bank0 lane0 (0->7) on the same edge as accepting a beat with in_set=0 -> that beat uses 0, the next beat uses 7.
- Counter: force 3 clamped beats with sat_clr asserted on the 3rd beat's stage-2 edge -> sat_cnt=0. Preload to 0xFFFF via saturating beats -> sat_cnt stays at 0xFFFF.
- Async reset with 2 beats in flight -> out_valid=0, out_data=0, sat_cnt=0 immediately; after release, a fresh beat using bank0 with bias 0 passes through unchanged.
